// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
// -----------------------------------------------------------------------------
// Registered RV32I control decoder at the ID/EX boundary. One instruction is
// decoded per cycle into a registered control bundle. FENCE drains the store
// buffer through a small wait FSM that gives up after FENCE_TIMEOUT cycles.
//
// Compile-time option: define RV32M_EXT_EN to decode the RV32M multiply/divide
// group (OP with funct7=0000001). Without it those encodings are illegal.
//
// Handshake: an instruction moves in on a rising edge when instr_valid_i and
// instr_ready_o are both high. instr_ready_o is high only in RUN with no stall
// and no flush, so it already folds in the downstream back-pressure.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   instr_valid_i/ready_o  input handshake
//   instr_i, pc_i          instruction word and its PC
//   stall_i                hold every output, freeze FSM and counter
//   flush_i                clear outputs, FSM back to RUN
//   store_buf_empty_i      no stores outstanding (FENCE drain condition)
//   ctrl_valid_o, pc_o     registered bundle valid flag and PC
//   *_en_o, imm_src_o ...  registered control bits
//   alu_op_o               ALU operation code
//   load_type_o            0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
//   store_type_o           0 none, 1 SB, 2 SH, 3 SW
//   illegal_instr_o        registered illegal-instruction flag
//   fence_timeout_o        one-cycle pulse on forced FENCE completion
//   fsm_state_o            debug view of the FSM (0 RUN, 1 FENCE_WAIT)
// -----------------------------------------------------------------------------
module decode_ctrl_stage #(
  parameter int XLEN          = 32,
  parameter int ALU_OP_W      = 5,
  parameter int FENCE_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [31:0]         instr_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                store_buf_empty_i,
  output logic                ctrl_valid_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                write_en_rf_o,
  output logic                write_en_dmem_o,
  output logic                data_read_o,
  output logic                alu_rd2_select_o,
  output logic                branch_en_o,
  output logic                jal_en_o,
  output logic                jalr_en_o,
  output logic                auipc_en_o,
  output logic                lui_en_o,
  output logic                imm_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [2:0]          load_type_o,
  output logic [1:0]          store_type_o,
  output logic                illegal_instr_o,
  output logic                fence_timeout_o,
  output logic                fsm_state_o
);

  localparam int CNT_W = (FENCE_TIMEOUT > 2) ? $clog2(FENCE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FENCE_TIMEOUT - 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic {
    RUN        = 1'b0,
    FENCE_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                write_en_rf;
    logic                write_en_dmem;
    logic                data_read;
    logic                alu_rd2_select;
    logic                branch_en;
    logic                jal_en;
    logic                jalr_en;
    logic                auipc_en;
    logic                lui_en;
    logic                imm_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          load_type;
    logic [1:0]          store_type;
    logic                illegal;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  fence_pc_q, fence_pc_d;
  logic             timeout_q, timeout_d;

  ctrl_t            dec;
  logic             dec_fence;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Register specifiers are consumed by the register file, not here.
  logic unused_fields;
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // ---------------------------------------------------------------------------
  // Combinational decode of instr_i
  // ---------------------------------------------------------------------------
  always_comb begin
    dec       = '0;
    dec_fence = 1'b0;
    unique case (opcode)
      OPC_LOAD: begin
        dec.write_en_rf    = 1'b1;
        dec.data_read      = 1'b1;
        dec.alu_rd2_select = 1'b1;
        unique case (funct3)
          3'b000:  dec.load_type = 3'd1;
          3'b001:  dec.load_type = 3'd2;
          3'b010:  dec.load_type = 3'd3;
          3'b100:  dec.load_type = 3'd4;
          3'b101:  dec.load_type = 3'd5;
          default: dec.illegal   = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.write_en_dmem  = 1'b1;
        dec.alu_rd2_select = 1'b1;
        unique case (funct3)
          3'b000:  dec.store_type = 2'd1;
          3'b001:  dec.store_type = 2'd2;
          3'b010:  dec.store_type = 2'd3;
          default: dec.illegal    = 1'b1;
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        dec.write_en_rf    = 1'b1;
        dec.alu_rd2_select = (opcode == OPC_OPIMM);
        unique case (funct3)
          // funct7[5] means SUB only for register-register ops; on OP-IMM
          // those bits belong to the immediate.
          3'b000:  dec.alu_op = (opcode == OPC_OP && funct7[5]) ? ALU_OP_W'(1) : ALU_OP_W'(0);
          3'b001:  dec.alu_op = ALU_OP_W'(2);
          3'b010:  dec.alu_op = ALU_OP_W'(5);
          3'b011:  dec.alu_op = ALU_OP_W'(6);
          3'b100:  dec.alu_op = ALU_OP_W'(7);
          3'b101:  dec.alu_op = funct7[5] ? ALU_OP_W'(4) : ALU_OP_W'(3);
          3'b110:  dec.alu_op = ALU_OP_W'(8);
          default: dec.alu_op = ALU_OP_W'(9);
        endcase
        if (opcode == OPC_OPIMM) begin
          if (funct3 == 3'b001 && funct7 != 7'b0000000)
            dec.illegal = 1'b1;
          if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
            dec.illegal = 1'b1;
        end else begin
          if (funct7 == 7'b0000001) begin
`ifdef RV32M_EXT_EN
            dec.alu_op = ALU_OP_W'(16 + int'(funct3));
`else
            dec.illegal = 1'b1;
`endif
          end else if (funct7 == 7'b0100000) begin
            if (funct3 != 3'b000 && funct3 != 3'b101)
              dec.illegal = 1'b1;
          end else if (funct7 != 7'b0000000) begin
            dec.illegal = 1'b1;
          end
        end
      end
      OPC_BRANCH: begin
        dec.branch_en = 1'b1;
        unique case (funct3)
          3'b000:  dec.alu_op  = ALU_OP_W'(10);
          3'b001:  dec.alu_op  = ALU_OP_W'(11);
          3'b100:  dec.alu_op  = ALU_OP_W'(12);
          3'b101:  dec.alu_op  = ALU_OP_W'(13);
          3'b110:  dec.alu_op  = ALU_OP_W'(14);
          3'b111:  dec.alu_op  = ALU_OP_W'(15);
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.write_en_rf    = 1'b1;
        dec.alu_rd2_select = 1'b1;
        dec.jal_en         = 1'b1;
      end
      OPC_JALR: begin
        dec.write_en_rf    = 1'b1;
        dec.alu_rd2_select = 1'b1;
        dec.jalr_en        = 1'b1;
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.write_en_rf = 1'b1;
        dec.lui_en      = 1'b1;
        dec.imm_src     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.write_en_rf = 1'b1;
        dec.auipc_en    = 1'b1;
        dec.imm_src     = 1'b1;
      end
      OPC_FENCE: dec_fence = 1'b1;
      default:   dec.illegal = 1'b1;
    endcase
    // An illegal encoding carries only the flag; every enable and field is 0.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and next-state logic
  // ---------------------------------------------------------------------------
  assign instr_ready_o = rst_ni && (state_q == RUN) && !stall_i && !flush_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    fence_pc_d = fence_pc_q;
    timeout_d  = timeout_q;
    if (flush_i) begin
      state_d   = RUN;
      cnt_d     = '0;
      valid_d   = 1'b0;
      ctrl_d    = '0;
      pc_d      = '0;
      timeout_d = 1'b0;
    end else if (!stall_i) begin
      // Default is a bubble: control cleared, pc_o holds.
      valid_d   = 1'b0;
      ctrl_d    = '0;
      timeout_d = 1'b0;
      unique case (state_q)
        RUN: begin
          if (instr_valid_i) begin
            if (dec_fence && !store_buf_empty_i) begin
              state_d    = FENCE_WAIT;
              cnt_d      = '0;
              fence_pc_d = pc_i;
            end else begin
              valid_d = 1'b1;
              ctrl_d  = dec;
              pc_d    = pc_i;
            end
          end
        end
        default: begin
          if (store_buf_empty_i || cnt_q == CNT_LAST) begin
            // Issue the captured FENCE as a NOP.
            valid_d   = 1'b1;
            pc_d      = fence_pc_q;
            state_d   = RUN;
            cnt_d     = '0;
            timeout_d = !store_buf_empty_i;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      fence_pc_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      fence_pc_q <= fence_pc_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ctrl_valid_o     = valid_q;
  assign pc_o             = pc_q;
  assign write_en_rf_o    = ctrl_q.write_en_rf;
  assign write_en_dmem_o  = ctrl_q.write_en_dmem;
  assign data_read_o      = ctrl_q.data_read;
  assign alu_rd2_select_o = ctrl_q.alu_rd2_select;
  assign branch_en_o      = ctrl_q.branch_en;
  assign jal_en_o         = ctrl_q.jal_en;
  assign jalr_en_o        = ctrl_q.jalr_en;
  assign auipc_en_o       = ctrl_q.auipc_en;
  assign lui_en_o         = ctrl_q.lui_en;
  assign imm_src_o        = ctrl_q.imm_src;
  assign alu_op_o         = ctrl_q.alu_op;
  assign load_type_o      = ctrl_q.load_type;
  assign store_type_o     = ctrl_q.store_type;
  assign illegal_instr_o  = ctrl_q.illegal;
  assign fence_timeout_o  = timeout_q;
  assign fsm_state_o      = state_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Testbench for decode_ctrl_stage: table of decode vectors plus hand-written
// sequences for stall, flush, bubble, FENCE drain, FENCE timeout and reset.
module tb_decode_ctrl_stage;

  localparam int XLEN = 32;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic            instr_valid_i, instr_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            stall_i, flush_i, store_buf_empty_i;
  logic            ctrl_valid_o;
  logic [XLEN-1:0] pc_o;
  logic            write_en_rf_o, write_en_dmem_o, data_read_o, alu_rd2_select_o;
  logic            branch_en_o, jal_en_o, jalr_en_o, auipc_en_o, lui_en_o, imm_src_o;
  logic [4:0]      alu_op_o;
  logic [2:0]      load_type_o;
  logic [1:0]      store_type_o;
  logic            illegal_instr_o, fence_timeout_o, fsm_state_o;

  decode_ctrl_stage #(.XLEN(XLEN), .ALU_OP_W(5), .FENCE_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .store_buf_empty_i(store_buf_empty_i),
    .ctrl_valid_o(ctrl_valid_o), .pc_o(pc_o),
    .write_en_rf_o(write_en_rf_o), .write_en_dmem_o(write_en_dmem_o),
    .data_read_o(data_read_o), .alu_rd2_select_o(alu_rd2_select_o),
    .branch_en_o(branch_en_o), .jal_en_o(jal_en_o), .jalr_en_o(jalr_en_o),
    .auipc_en_o(auipc_en_o), .lui_en_o(lui_en_o), .imm_src_o(imm_src_o),
    .alu_op_o(alu_op_o), .load_type_o(load_type_o), .store_type_o(store_type_o),
    .illegal_instr_o(illegal_instr_o), .fence_timeout_o(fence_timeout_o),
    .fsm_state_o(fsm_state_o)
  );

  // Bundle layout: {valid, illegal, wrf, wdmem, rd, rd2sel, br, jal, jalr,
  // auipc, lui, imm_src, alu_op[4:0], load[2:0], store[1:0]}
  logic [21:0] bundle;
  assign bundle = {ctrl_valid_o, illegal_instr_o, write_en_rf_o, write_en_dmem_o,
                   data_read_o, alu_rd2_select_o, branch_en_o, jal_en_o, jalr_en_o,
                   auipc_en_o, lui_en_o, imm_src_o, alu_op_o, load_type_o, store_type_o};

  // Enable masks {wrf, wdmem, rd, rd2sel, br, jal, jalr, auipc, lui, imm_src}
  localparam logic [9:0] EN_LOAD  = 10'b1011000000;
  localparam logic [9:0] EN_STORE = 10'b0101000000;
  localparam logic [9:0] EN_OPIMM = 10'b1001000000;
  localparam logic [9:0] EN_OP    = 10'b1000000000;
  localparam logic [9:0] EN_BR    = 10'b0000100000;
  localparam logic [9:0] EN_JAL   = 10'b1001010000;
  localparam logic [9:0] EN_JALR  = 10'b1001001000;
  localparam logic [9:0] EN_LUI   = 10'b1000000011;
  localparam logic [9:0] EN_AUIPC = 10'b1000000101;
  localparam logic [9:0] EN_NONE  = 10'b0000000000;

  function automatic logic [21:0] mk(input logic v, input logic ill, input logic [9:0] en,
                                     input int alu, input int ld, input int st);
    return {v, ill, en, 5'(alu), 3'(ld), 2'(st)};
  endfunction

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [21:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [21:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [31:0] instr, input logic [21:0] exp);
    vec_t v;
    v.name = name; v.instr = instr; v.exp = exp;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc);
    instr_valid_i = v;
    instr_i       = ins;
    pc_i          = pc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD   = 32'h00208033;
  localparam logic [31:0] I_SUB   = 32'h40208033;
  localparam logic [31:0] I_LW    = 32'h00012083;
  localparam logic [31:0] I_FENCE = 32'h0FF0000F;

  initial begin
    instr_valid_i = 1'b0; instr_i = '0; pc_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; store_buf_empty_i = 1'b1;

    // ------------------------------------------------------------ vector table
    add_vec("sub",        I_SUB,        mk(1, 0, EN_OP,    1, 0, 0));
    add_vec("add",        I_ADD,        mk(1, 0, EN_OP,    0, 0, 0));
    add_vec("all_ones",   32'hFFFFFFFF, mk(1, 1, EN_NONE,  0, 0, 0));
`ifdef RV32M_EXT_EN
    add_vec("mul",        32'h02208033, mk(1, 0, EN_OP,   16, 0, 0));
    add_vec("mulhu",      32'h0220B033, mk(1, 0, EN_OP,   19, 0, 0));
`else
    add_vec("mul",        32'h02208033, mk(1, 1, EN_NONE,  0, 0, 0));
    add_vec("mulhu",      32'h0220B033, mk(1, 1, EN_NONE,  0, 0, 0));
`endif
    add_vec("lw",         I_LW,         mk(1, 0, EN_LOAD,  0, 3, 0));
    add_vec("lbu",        32'h00014083, mk(1, 0, EN_LOAD,  0, 4, 0));
    add_vec("load_f3_3",  32'h00013083, mk(1, 1, EN_NONE,  0, 0, 0));
    add_vec("sw",         32'h00112023, mk(1, 0, EN_STORE, 0, 0, 3));
    add_vec("sb",         32'h00110023, mk(1, 0, EN_STORE, 0, 0, 1));
    add_vec("store_f3_3", 32'h00113023, mk(1, 1, EN_NONE,  0, 0, 0));
    add_vec("addi",       32'h00100093, mk(1, 0, EN_OPIMM, 0, 0, 0));
    add_vec("addi_hi",    32'h40000093, mk(1, 0, EN_OPIMM, 0, 0, 0));
    add_vec("srai",       32'h40105093, mk(1, 0, EN_OPIMM, 4, 0, 0));
    add_vec("srli",       32'h00105093, mk(1, 0, EN_OPIMM, 3, 0, 0));
    add_vec("slli_bad",   32'h40101093, mk(1, 1, EN_NONE,  0, 0, 0));
    add_vec("sra",        32'h40205033, mk(1, 0, EN_OP,    4, 0, 0));
    add_vec("op_bad_f7",  32'h40201033, mk(1, 1, EN_NONE,  0, 0, 0));
    add_vec("sltu",       32'h0020B033, mk(1, 0, EN_OP,    6, 0, 0));
    add_vec("and",        32'h0020F033, mk(1, 0, EN_OP,    9, 0, 0));
    add_vec("beq",        32'h00208063, mk(1, 0, EN_BR,   10, 0, 0));
    add_vec("bgeu",       32'h0020F063, mk(1, 0, EN_BR,   15, 0, 0));
    add_vec("br_f3_2",    32'h0020A063, mk(1, 1, EN_NONE,  0, 0, 0));
    add_vec("jal",        32'h0000006F, mk(1, 0, EN_JAL,   0, 0, 0));
    add_vec("jalr",       32'h00008067, mk(1, 0, EN_JALR,  0, 0, 0));
    add_vec("jalr_f3_1",  32'h00009067, mk(1, 1, EN_NONE,  0, 0, 0));
    add_vec("lui",        32'h000010B7, mk(1, 0, EN_LUI,   0, 0, 0));
    add_vec("auipc",      32'h00001097, mk(1, 0, EN_AUIPC, 0, 0, 0));
    add_vec("fence_now",  I_FENCE,      mk(1, 0, EN_NONE,  0, 0, 0));
    add_vec("opc_zero",   32'h00000000, mk(1, 1, EN_NONE,  0, 0, 0));

    // ------------------------------------------------------------ reset state
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    tick(); tick();
    check("reset_bundle", bundle, 0);
    check("reset_pc", pc_o, 0);
    check("reset_misc", {instr_ready_o, fence_timeout_o, fsm_state_o}, 0);
    @(negedge clk) rst_ni = 1'b1;
    #1 check("ready_after_reset", instr_ready_o, 1);

    // ------------------------------------------------------------ table loop
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(4 * i));
      exp_q.push_back(vecs[i].exp);
      tick();
      check(vecs[i].name, bundle, exp_q.pop_front());
      check("vec_pc", pc_o, 32'h1000 + 32'(4 * i));
    end

    // ------------------------------------------------------------ bubble
    @(negedge clk) drive(1'b0, I_ADD, 32'hDEAD0000);
    tick();
    check("bubble_bundle", bundle, 0);
    check("bubble_pc_hold", pc_o, 32'h1000 + 32'(4 * (vecs.size() - 1)));

    // ------------------------------------------------------------ stall
    @(negedge clk) drive(1'b1, I_LW, 32'h2000);
    tick();
    check("lw_issue", bundle, mk(1, 0, EN_LOAD, 0, 3, 0));
    @(negedge clk) begin
      stall_i = 1'b1;
      drive(1'b1, I_ADD, 32'h2004);
    end
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_ready", instr_ready_o, 0);
      tick();
      check("stall_hold", bundle, mk(1, 0, EN_LOAD, 0, 3, 0));
      check("stall_pc_hold", pc_o, 32'h2000);
      @(negedge clk);
    end
    stall_i = 1'b0;
    #1 check("unstall_ready", instr_ready_o, 1);
    tick();
    check("after_stall_add", bundle, mk(1, 0, EN_OP, 0, 0, 0));
    check("after_stall_pc", pc_o, 32'h2004);

    // ------------------------------------------------------------ flush
    @(negedge clk) begin
      flush_i = 1'b1;
      drive(1'b1, I_SUB, 32'h2008);
    end
    #1 check("flush_ready", instr_ready_o, 0);
    tick();
    check("flush_bundle", bundle, 0);
    check("flush_pc", pc_o, 0);
    @(negedge clk) begin
      flush_i = 1'b0;
      drive(1'b0, I_ADD, 32'h0);
    end

    // ------------------------------------------------------------ FENCE drain
    @(negedge clk) begin
      store_buf_empty_i = 1'b0;
      drive(1'b1, I_FENCE, 32'h3000);
    end
    tick();
    check("fence_capture", {ctrl_valid_o, instr_ready_o, fsm_state_o}, 3'b001);
    @(negedge clk) drive(1'b1, I_ADD, 32'h3004);
    for (int k = 0; k < 3; k++) begin
      #1 check("drain_ready", instr_ready_o, 0);
      tick();
      check("drain_wait", {ctrl_valid_o, fence_timeout_o}, 0);
      @(negedge clk);
    end
    store_buf_empty_i = 1'b1;
    tick();
    check("drain_nop", bundle, mk(1, 0, EN_NONE, 0, 0, 0));
    check("drain_pc", pc_o, 32'h3000);
    check("drain_no_timeout", fence_timeout_o, 0);
    check("drain_run", {instr_ready_o, fsm_state_o}, 2'b10);
    tick();
    check("drain_next_add", bundle, mk(1, 0, EN_OP, 0, 0, 0));
    check("drain_next_pc", pc_o, 32'h3004);

    // ------------------------------------------------------------ FENCE timeout
    @(negedge clk) begin
      store_buf_empty_i = 1'b0;
      drive(1'b1, I_FENCE, 32'h4000);
    end
    tick();
    check("to_capture", {ctrl_valid_o, instr_ready_o, fsm_state_o}, 3'b001);
    @(negedge clk) drive(1'b0, I_ADD, 32'h0);
    for (int k = 1; k < 16; k++) begin
      tick();
      check("to_wait", {ctrl_valid_o, fence_timeout_o}, 0);
    end
    tick();
    check("to_pulse", {ctrl_valid_o, fence_timeout_o}, 2'b11);
    check("to_nop", bundle, mk(1, 0, EN_NONE, 0, 0, 0));
    check("to_pc", pc_o, 32'h4000);
    tick();
    check("to_pulse_end", {fence_timeout_o, ctrl_valid_o}, 0);
    check("to_run", {instr_ready_o, fsm_state_o}, 2'b10);
    @(negedge clk) store_buf_empty_i = 1'b1;

    // ------------------------------------------------------------ mid-stream reset
    @(negedge clk) drive(1'b1, I_SUB, 32'h5000);
    tick();
    check("pre_reset_sub", bundle, mk(1, 0, EN_OP, 1, 0, 0));
    #2 rst_ni = 1'b0;
    #1;
    check("midreset_bundle", bundle, 0);
    check("midreset_pc", pc_o, 0);
    check("midreset_ready", instr_ready_o, 0);
    @(negedge clk) begin
      rst_ni = 1'b1;
      drive(1'b1, I_ADD, 32'h5004);
    end
    tick();
    check("post_reset_add", bundle, mk(1, 0, EN_OP, 0, 0, 0));
    check("post_reset_pc", pc_o, 32'h5004);
    @(negedge clk) drive(1'b0, I_ADD, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
